// File: rtl/handshake_rr_arbiter.sv
// rtl/handshake_rr_arbiter.sv - round-robin source arbiter with registered 2-entry skid output
// ARB_BURST_EN: when defined, a grant holds for up to BURST_LEN beats; otherwise one beat per grant.
module handshake_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_SRC   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       s_rst_n,
    input  logic [NUM_SRC-1:0]         src_vaild,
    input  logic [NUM_SRC*WIDTH-1:0]   src_data_in,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic                       dst_ready,
    output logic                       dst_vaild,
    output logic [WIDTH-1:0]           dst_data_out,
    output logic [$clog2(NUM_SRC)-1:0] dst_src_id
);

    localparam int IDW = $clog2(NUM_SRC);
    localparam int CW  = $clog2(BURST_LEN + 1);
`ifdef ARB_BURST_EN
    localparam logic [CW-1:0] BURST_LIMIT = CW'(BURST_LEN);
`else
    localparam logic [CW-1:0] BURST_LIMIT = CW'(1);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_SRC-1:0] src_ready_q, src_ready_d;

    logic               main_vld_q, main_vld_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [IDW-1:0]     main_id_q, main_id_d;
    logic               skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [IDW-1:0]     skid_id_q, skid_id_d;

    logic               src_fire;
    logic               dst_fire;
    logic [WIDTH-1:0]   src_beat;
    logic               rr_found;
    logic [IDW-1:0]     rr_pick;

    // src_ready_q is only ever set for grant_q, so this is the single possible source transfer.
    assign src_fire = src_ready_q[grant_q] & src_vaild[grant_q];
    assign dst_fire = main_vld_q & dst_ready;
    assign src_beat = src_data_in[int'(grant_q)*WIDTH +: WIDTH];

    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!rr_found && src_vaild[(int'(last_grant_q) + k) % NUM_SRC]) begin
                rr_found = 1'b1;
                rr_pick  = IDW'((int'(last_grant_q) + k) % NUM_SRC);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d      = GRANT;
                    grant_d      = rr_pick;
                    last_grant_d = rr_pick;
                    cnt_d        = '0;
                end
            end
            GRANT: begin
                if (!src_vaild[grant_q] || (src_fire && (cnt_q + 1'b1 == BURST_LIMIT))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (src_fire) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid only fills when main is held by a stalled downstream; pops drain skid first to keep order.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_id_d   = main_id_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_id_d   = skid_id_q;
        if (dst_fire) begin
            if (skid_vld_q) begin
                main_data_d = skid_data_q;
                main_id_d   = skid_id_q;
                if (src_fire) begin
                    skid_data_d = src_beat;
                    skid_id_d   = grant_q;
                end else begin
                    skid_vld_d = 1'b0;
                end
            end else if (src_fire) begin
                main_data_d = src_beat;
                main_id_d   = grant_q;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (src_fire) begin
            if (!main_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = src_beat;
                main_id_d   = grant_q;
            end else begin
                skid_vld_d  = 1'b1;
                skid_data_d = src_beat;
                skid_id_d   = grant_q;
            end
        end
    end

    always_comb begin
        src_ready_d = '0;
        if (state_d == GRANT && !skid_vld_d) begin
            src_ready_d[grant_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_SRC - 1);
            cnt_q        <= '0;
            src_ready_q  <= '0;
            main_vld_q   <= 1'b0;
            main_data_q  <= '0;
            main_id_q    <= '0;
            skid_vld_q   <= 1'b0;
            skid_data_q  <= '0;
            skid_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            src_ready_q  <= src_ready_d;
            main_vld_q   <= main_vld_d;
            main_data_q  <= main_data_d;
            main_id_q    <= main_id_d;
            skid_vld_q   <= skid_vld_d;
            skid_data_q  <= skid_data_d;
            skid_id_q    <= skid_id_d;
        end
    end

    assign src_ready    = src_ready_q;
    assign dst_vaild    = main_vld_q;
    assign dst_data_out = main_data_q;
    assign dst_src_id   = main_id_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb/tb_handshake_rr_arbiter.sv - directed self-checking bench for handshake_rr_arbiter
module tb_handshake_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int NUM_SRC   = 4;
    localparam int BURST_LEN = 4;

    logic        clk = 1'b0;
    logic        s_rst_n;
    logic [3:0]  src_vaild;
    logic [31:0] src_data_in;
    logic [3:0]  src_ready;
    logic        dst_ready;
    logic        dst_vaild;
    logic [7:0]  dst_data_out;
    logic [1:0]  dst_src_id;

    always #5 clk = ~clk;

    handshake_rr_arbiter #(
        .WIDTH     (WIDTH),
        .NUM_SRC   (NUM_SRC),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk          (clk),
        .s_rst_n      (s_rst_n),
        .src_vaild    (src_vaild),
        .src_data_in  (src_data_in),
        .src_ready    (src_ready),
        .dst_ready    (dst_ready),
        .dst_vaild    (dst_vaild),
        .dst_data_out (dst_data_out),
        .dst_src_id   (dst_src_id)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] base [4];
    int         len  [4];
    int         ptr  [4];
    int         sc;
    int         occ;
    int         rdy_mode;
    int         first_rdy_sc;
    int         first_dv_sc;
    logic [3:0] vh1, vh2;
    logic [7:0] exp_id[$], exp_data[$], cap_id[$], cap_data[$];
    int         cap_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            src_vaild[i]          = (ptr[i] < len[i]);
            src_data_in[i*8 +: 8] = base[i] + 8'(ptr[i]);
        end
        case (rdy_mode)
            0:       dst_ready = 1'b1;
            1:       dst_ready = (sc % 2 == 0);
            default: dst_ready = 1'b0;
        endcase
    endtask

    // Sample at the falling edge, let the rising edge act, then advance the source models.
    task automatic cycle();
        logic [3:0] sfire;
        logic       dfire;
        @(negedge clk);
        sfire = src_vaild & src_ready;
        dfire = dst_vaild & dst_ready;
        check("onehot", 32'($countones(src_ready) <= 1), 1);
        if (occ == 2) check("skid_full_rdy", 32'(src_ready), 0);
        for (int i = 0; i < 4; i++) begin
            if (vh2[i] && !vh1[i]) check("rdy_after_drop", 32'(src_ready[i]), 0);
        end
        vh2 = vh1;
        vh1 = src_vaild;
        if (first_rdy_sc < 0 && src_ready != 4'd0) first_rdy_sc = sc;
        if (first_dv_sc < 0 && dst_vaild) first_dv_sc = sc;
        if (dfire) begin
            cap_id.push_back(8'(dst_src_id));
            cap_data.push_back(dst_data_out);
            cap_cyc.push_back(sc);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (sfire[i]) ptr[i]++;
        end
        occ = occ + ((sfire != 4'd0) ? 1 : 0) - (dfire ? 1 : 0);
        sc++;
        drive();
    endtask

    task automatic do_reset();
        s_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ptr[i]  = 0;
            len[i]  = 0;
            base[i] = 8'h00;
        end
        occ = 0; sc = 0; rdy_mode = 0;
        vh1 = '0; vh2 = '0;
        first_rdy_sc = -1; first_dv_sc = -1;
        exp_id.delete(); exp_data.delete();
        cap_id.delete(); cap_data.delete(); cap_cyc.delete();
        drive();
        #1;
        check("rst_src_ready", 32'(src_ready), 0);
        check("rst_dst_vaild", 32'(dst_vaild), 0);
        check("rst_dst_data", 32'(dst_data_out), 0);
        check("rst_dst_id", 32'(dst_src_id), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        s_rst_n = 1'b1;
    endtask

    task automatic run_until(input int n, input string tag);
        int budget = 400;
        while (cap_id.size() < n && budget > 0) begin
            cycle();
            budget--;
        end
        repeat (6) cycle();
        check({tag, "_count"}, 32'(cap_id.size()), 32'(n));
        for (int k = 0; k < n && k < cap_id.size(); k++) begin
            check({tag, "_id"}, 32'(cap_id[k]), 32'(exp_id[k]));
            check({tag, "_data"}, 32'(cap_data[k]), 32'(exp_data[k]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, k;
        // Reset state, then quiet cycles: nothing may move without requests.
        do_reset();
        cycle();
        check("quiet_rdy", 32'(src_ready), 0);
        check("quiet_dv", 32'(dst_vaild), 0);
        cycle();
        check("quiet_rdy2", 32'(src_ready), 0);

        // All four sources requesting continuously, downstream always ready.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            base[i] = 8'(8'h10 * (i + 1));
            len[i]  = 8;
        end
        for (int i = 0; i < 32; i++) begin
`ifdef ARB_BURST_EN
            s = (i % 16) / 4;
            k = (i / 16) * 4 + i % 4;
`else
            s = i % 4;
            k = i / 4;
`endif
            exp_id.push_back(8'(s));
            exp_data.push_back(base[s] + 8'(k));
        end
        drive();
        run_until(32, "rr");
`ifdef ARB_BURST_EN
        for (int j = 1; j < cap_cyc.size(); j++) begin
            if (j % 4 != 0) check("burst_gap", 32'(cap_cyc[j] - cap_cyc[j-1]), 1);
        end
`endif

        // Source 2 alone, A0..A9, downstream ready toggling.
        do_reset();
        base[2] = 8'hA0;
        len[2]  = 10;
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            exp_id.push_back(8'd2);
            exp_data.push_back(8'hA0 + 8'(i));
        end
        drive();
        run_until(10, "skid");
        check("grant_latency", 32'(first_rdy_sc), 1);
        check("dst_latency", 32'(first_dv_sc), 2);

        // Source 1 stops after two beats while source 3 keeps requesting.
        do_reset();
        base[1] = 8'h51; len[1] = 2;
        base[3] = 8'h70; len[3] = 4;
`ifdef ARB_BURST_EN
        exp_id   = '{8'd1, 8'd1, 8'd3, 8'd3, 8'd3, 8'd3};
        exp_data = '{8'h51, 8'h52, 8'h70, 8'h71, 8'h72, 8'h73};
`else
        exp_id   = '{8'd1, 8'd3, 8'd1, 8'd3, 8'd3, 8'd3};
        exp_data = '{8'h51, 8'h70, 8'h52, 8'h71, 8'h72, 8'h73};
`endif
        drive();
        run_until(6, "drop");

        // Reset mid-burst with both buffer entries occupied, then restart from source 0.
        do_reset();
        base[1] = 8'h11; len[1] = 10;
        rdy_mode = 2;
        drive();
        repeat (6) cycle();
        check("fill_occ", 32'(occ), 2);
        check("fill_dv", 32'(dst_vaild), 1);
        do_reset();
        base[0] = 8'h30; len[0] = 4;
        base[2] = 8'hC0; len[2] = 4;
`ifdef ARB_BURST_EN
        exp_id   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2};
        exp_data = '{8'h30, 8'h31, 8'h32, 8'h33, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
`else
        exp_id   = '{8'd0, 8'd2, 8'd0, 8'd2, 8'd0, 8'd2, 8'd0, 8'd2};
        exp_data = '{8'h30, 8'hC0, 8'h31, 8'hC1, 8'h32, 8'hC2, 8'h33, 8'hC3};
`endif
        drive();
        run_until(8, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/handshake_rr_arbiter.md
HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width per source, in bits.
REQ-002 Parameter NUM_SRC, default 4: number of requesting sources (2..8).
REQ-003 Parameter BURST_LEN, default 4: the maximum number of beats accepted per grant (1..16).
REQ-004 Port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-005 Port s_rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port src_vaild, input, NUM_SRC: per-source valid, bit i for source i.
REQ-007 Port src_data_in, input, NUM_SRC*WIDTH: source i data occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port src_ready, output, NUM_SRC: per-source ready, driven from a register.
REQ-009 Port dst_ready, input, 1: downstream ready.
REQ-010 Port dst_vaild, output, 1: downstream valid, driven from a register.
REQ-011 Port dst_data_out, output, WIDTH: downstream data, driven from a register.
REQ-012 Port dst_src_id, output, ceil(log2(NUM_SRC)): index of the source that produced dst_data_out; it is driven from a register.

Function
REQ-013 A source beat transfers when src_vaild[i] and src_ready[i] are both high at a clock edge; a downstream beat transfers when dst_vaild and dst_ready are both high.
REQ-014 The FSM has two states. IDLE: no grant. GRANT: exactly one granted source, with a beat counter.
REQ-015 In IDLE, when any src_vaild bit is high, the FSM grants the first requester found by searching upward from (last_grant+1) mod NUM_SRC, moves to GRANT, and clears the counter.
REQ-016 src_ready[i] SHALL be high only for the granted source, and never in IDLE; at most one bit is high in any cycle.
REQ-017 Latency: a grant decided at edge N produces src_ready high in cycle N+1, provided buffer space exists.
REQ-018 The output path is a 2-entry buffer (main register plus skid register) that preserves beat order.
REQ-019 src_ready is registered as follows: it is high next cycle only if the skid register will be empty next cycle and the grant continues.
REQ-020 No beat is ever lost or duplicated.
REQ-021 Source-to-destination latency is 1 cycle when the buffer is empty: a beat accepted at edge N gives dst_vaild high after edge N.
REQ-022 When dst_vaild is high and dst_ready is low, dst_data_out and dst_src_id SHALL hold stable.
REQ-023 The grant is released (GRANT->IDLE) on the edge where the counter reaches the burst limit.
REQ-024 The grant is also released on the edge where the granted source's src_vaild is low.
REQ-025 src_ready for that source SHALL be low in the cycle following release.
REQ-026 last_grant updates on every grant. A released source cannot be regranted before every other requesting source has been served once.
REQ-027 Simultaneous downstream pop and source push with a full main register: the main register takes the new beat, or the skid contents if the skid is occupied. There is no stall bubble.

Reset
REQ-028 On assertion of s_rst_n (async, low), the block SHALL clear: src_ready to 0, dst_vaild to 0, dst_data_out to 0, dst_src_id to 0, the FSM to IDLE, the counter to 0, the skid register to empty, and last_grant to NUM_SRC-1.
REQ-029 Reset asserted mid-burst discards buffered beats; after release, arbitration restarts from source 0 priority.
REQ-030 Reset deassertion is synchronised by the integrating system; no output SHALL toggle in the first cycle after release.

Configuration
REQ-031 Macro ARB_BURST_EN defined: the burst limit is BURST_LEN beats per grant.
REQ-032 Macro ARB_BURST_EN undefined: the burst limit is 1, so the block re-arbitrates after every accepted beat and BURST_LEN is ignored.

Verification
REQ-033 All sources request continuously with dst_ready=1, ARB_BURST_EN defined. Required: grants in the order 0,1,2,3,0,...; 4 consecutive beats per source; dst_src_id sequence 0000111122223333; no idle cycles within a burst.
REQ-034 Same stimulus with ARB_BURST_EN undefined. Required: dst_src_id follows 0,1,2,3,0,... beat by beat.
REQ-035 Source 2 alone sends data 0xA0..0xA9 while dst_ready toggles 1,0,1,0. Required: dst_data_out is 0xA0..0xA9 in order with no loss or duplication; src_ready[2] is low whenever the skid is full.
REQ-036 Source 1 drops src_vaild after 2 beats while source 3 is requesting. Required: src_ready[1] is low the next cycle; source 3 is granted next.
REQ-037 s_rst_n pulses low mid-burst with the buffer full. Required: all outputs are 0 immediately; after release, with sources 0 and 2 requesting, source 0 is granted first.
